neuron_dot_engine: RTL

//  Fabric-side Avalon-MM master that feeds the HPS system's img/weight slave ports under its control conduit.
//  On start: reads kernel_size image words and weight words, signed multiply-accumulates them, and writes
//  one saturated 32-bit result back through the img port. Raises done until cleared.

---
 rtl/neuron_pkg.sv | 30 +++
 rtl/neuron_mac.sv | 45 ++++
 rtl/neuron_dot_engine.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron dot-product engine: FSM state encoding,
// default operand/accumulator widths and the signed 32-bit saturation function.
package neuron_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int ACC_W_DEFAULT  = 40;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MAC,
        WRITE,
        DONE
    } neuronState_e;

    localparam logic signed [63:0] SAT_MAX = 64'sd2147483647;
    localparam logic signed [63:0] SAT_MIN = -64'sd2147483648;

    // Callers sign-extend their accumulator to 64 bits before saturating.
    function automatic logic [31:0] sat32(input logic signed [63:0] value);
        if (value > SAT_MAX) begin
            return 32'h7FFF_FFFF;
        end else if (value < SAT_MIN) begin
            return 32'h8000_0000;
        end else begin
            return value[31:0];
        end
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// Signed multiply-accumulate datapath. The next-state accumulator is exported so the
// controller can register the result in the same cycle the final product lands.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ACC_W  = ACC_W_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     enable_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  accNext_o
);

    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    assign product = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) *
                     $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});

    // The accumulator wraps modulo 2^ACC_W; ACC_W leaves ample headroom over 255 products.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (enable_i) begin
            acc_d = acc_q + {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign accNext_o = acc_d;

endmodule

// File: rtl/neuron_dot_engine.sv
// Avalon-MM master computing a saturated signed dot product of image and weight words.
// Optional macro NEURON_RELU_EN clamps negative results to zero before saturation.
module neuron_dot_engine
    import neuron_pkg::*;
#(
    parameter int          DATA_W      = DATA_W_DEFAULT,
    parameter int          ACC_W       = ACC_W_DEFAULT,
    parameter logic [29:0] WEIGHT_BASE = 30'h0
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        ctl_start,
    input  logic        ctl_clear,
    input  logic [7:0]  ctl_kernel_size,
    input  logic [31:0] ctl_base_addr,
    output logic        ctl_done,
    output logic        img_read,
    output logic        img_write,
    output logic [29:0] img_address,
    output logic [31:0] img_writedata,
    input  logic [31:0] img_readdata,
    input  logic        img_waitrequest,
    output logic        weight_read,
    output logic        weight_write,
    output logic [29:0] weight_address,
    output logic [31:0] weight_writedata,
    input  logic [31:0] weight_readdata,
    input  logic        weight_waitrequest
);

    neuronState_e             state_q;
    logic [29:0]              baseWord_q;
    logic [29:0]              imgAddress_q;
    logic [29:0]              weightAddress_q;
    logic [7:0]               kernelN_q;
    logic [7:0]               index_q;
    logic                     imgRead_q;
    logic                     imgWrite_q;
    logic                     weightRead_q;
    logic                     imgGot_q;
    logic                     weightGot_q;
    logic                     done_q;
    logic                     startPrev_q;
    logic                     abort_q;
    logic [31:0]              writeData_q;
    logic signed [DATA_W-1:0] imgData_q;
    logic signed [DATA_W-1:0] weightData_q;

    logic signed [ACC_W-1:0]  accNext;
    logic signed [63:0]       accWide;
    logic [31:0]              resultWord;
    logic [7:0]               nextIndex;
    logic                     launch;
    logic                     imgAccept;
    logic                     weightAccept;
    logic                     writeAccept;
    logic                     fetchDone;
    logic                     unusedBits;

    assign launch       = ctl_start && !startPrev_q && !ctl_clear;
    assign imgAccept    = imgRead_q && !img_waitrequest;
    assign weightAccept = weightRead_q && !weight_waitrequest;
    assign writeAccept  = imgWrite_q && !img_waitrequest;
    assign fetchDone    = (imgGot_q || imgAccept) && (weightGot_q || weightAccept);
    assign nextIndex    = index_q + 8'd1;

    neuron_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk_i     (clk_clk),
        .rst_ni    (reset_reset_n),
        .clear_i   ((state_q == IDLE) && launch),
        .enable_i  ((state_q == MAC) && !ctl_clear),
        .a_i       (imgData_q),
        .b_i       (weightData_q),
        .accNext_o (accNext)
    );

    assign accWide = {{(64-ACC_W){accNext[ACC_W-1]}}, accNext};

    always_comb begin
`ifdef NEURON_RELU_EN
        resultWord = accWide[63] ? 32'h0 : sat32(accWide);
`else
        resultWord = sat32(accWide);
`endif
    end

    // A clear seen in FETCH/WRITE is remembered in abort_q so open transfers finish first.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q         <= IDLE;
            baseWord_q      <= '0;
            imgAddress_q    <= '0;
            weightAddress_q <= '0;
            kernelN_q       <= '0;
            index_q         <= '0;
            imgRead_q       <= 1'b0;
            imgWrite_q      <= 1'b0;
            weightRead_q    <= 1'b0;
            imgGot_q        <= 1'b0;
            weightGot_q     <= 1'b0;
            done_q          <= 1'b0;
            startPrev_q     <= 1'b0;
            abort_q         <= 1'b0;
            writeData_q     <= '0;
            imgData_q       <= '0;
            weightData_q    <= '0;
        end else begin
            startPrev_q <= ctl_start;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        baseWord_q   <= ctl_base_addr[31:2];
                        kernelN_q    <= ctl_kernel_size;
                        index_q      <= '0;
                        abort_q      <= 1'b0;
                        imgAddress_q <= ctl_base_addr[31:2];
                        if (ctl_kernel_size == 8'd0) begin
                            state_q     <= WRITE;
                            imgWrite_q  <= 1'b1;
                            writeData_q <= '0;
                        end else begin
                            state_q         <= FETCH;
                            imgRead_q       <= 1'b1;
                            weightRead_q    <= 1'b1;
                            weightAddress_q <= WEIGHT_BASE;
                            imgGot_q        <= 1'b0;
                            weightGot_q     <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    if (ctl_clear) begin
                        abort_q <= 1'b1;
                    end
                    if (imgAccept) begin
                        imgRead_q <= 1'b0;
                        imgGot_q  <= 1'b1;
                        imgData_q <= img_readdata[DATA_W-1:0];
                    end
                    if (weightAccept) begin
                        weightRead_q <= 1'b0;
                        weightGot_q  <= 1'b1;
                        weightData_q <= weight_readdata[DATA_W-1:0];
                    end
                    if (fetchDone) begin
                        state_q <= (abort_q || ctl_clear) ? IDLE : MAC;
                    end
                end
                MAC: begin
                    if (ctl_clear) begin
                        state_q <= IDLE;
                    end else begin
                        index_q <= nextIndex;
                        if (nextIndex == kernelN_q) begin
                            state_q      <= WRITE;
                            imgWrite_q   <= 1'b1;
                            imgAddress_q <= baseWord_q + 30'(kernelN_q);
                            writeData_q  <= resultWord;
                        end else begin
                            state_q         <= FETCH;
                            imgRead_q       <= 1'b1;
                            weightRead_q    <= 1'b1;
                            imgAddress_q    <= baseWord_q + 30'(nextIndex);
                            weightAddress_q <= WEIGHT_BASE + 30'(nextIndex);
                            imgGot_q        <= 1'b0;
                            weightGot_q     <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (ctl_clear) begin
                        abort_q <= 1'b1;
                    end
                    if (writeAccept) begin
                        imgWrite_q <= 1'b0;
                        if (abort_q || ctl_clear) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (ctl_clear) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ctl_done         = done_q;
    assign img_read         = imgRead_q;
    assign img_write        = imgWrite_q;
    assign img_address      = imgAddress_q;
    assign img_writedata    = writeData_q;
    assign weight_read      = weightRead_q;
    assign weight_write     = 1'b0;
    assign weight_address   = weightAddress_q;
    assign weight_writedata = '0;

    assign unusedBits = ^{img_readdata[31:DATA_W], weight_readdata[31:DATA_W], ctl_base_addr[1:0]};

endmodule
